// File: rtl/fp_addsub_pipe.sv
// Floating-point add/subtract (IEEE-754 style, parameterised widths), round-to-nearest-even.
// Latency: result valid 3 cycles after the accepting clock edge; one result per cycle when unstalled.
// Backpressure: single global advance (!out_valid || out_ready) drives in_ready and freezes all stages.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake; op (0 = a+b, 1 = a-b), a, b sampled on transfer
//   out_valid/out_ready result handshake; c held stable while stalled
//   flags               {invalid, overflow, underflow, inexact}, only with FP_ADDSUB_FLAGS_EN defined
//
// Pipeline: operand register -> S1 (unpack, specials, swap, align) -> S2 (add, LZC, normalise)
//           -> S3 (round, pack) into the output register.
// Subnormal inputs read as signed zero; subnormal results flush to signed zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   c
`ifdef FP_ADDSUB_FLAGS_EN
  ,
  output logic [3:0]             flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 3;  // hidden + mantissa + guard + round
  localparam int SW = MAN_W + 4;  // AW plus sticky
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- operand register ----------------
  logic         v0, op0;
  logic [W-1:0] a0, b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0  <= 1'b0;
      op0 <= 1'b0;
      a0  <= '0;
      b0  <= '0;
    end else if (adv) begin
      v0 <= in_valid;
      if (in_valid) begin
        op0 <= op;
        a0  <= a;
        b0  <= b;
      end
    end
  end

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic             sa, sb, a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic             swap, sign_l, nan1, spec1;
  logic [W-2:0]     a_mag, b_mag, mag_l, mag_s;
  logic [EXP_W-1:0] exp_l, exp_s, diff;
  logic [MAN_W:0]   sig_l, sig_s;
  logic [2*AW-1:0]  al;
  logic [SW-1:0]    ml, ms;
  logic [W-1:0]     spec_res1;
  int               sh;

  always_comb begin
    sa     = a0[W-1];
    sb     = b0[W-1] ^ op0;
    a_max  = (a0[W-2:MAN_W] == EXP_ONES);
    b_max  = (b0[W-2:MAN_W] == EXP_ONES);
    a_nan  = a_max && (a0[MAN_W-1:0] != '0);
    b_nan  = b_max && (b0[MAN_W-1:0] != '0);
    a_inf  = a_max && (a0[MAN_W-1:0] == '0);
    b_inf  = b_max && (b0[MAN_W-1:0] == '0);
    a_zero = (a0[W-2:MAN_W] == '0);
    b_zero = (b0[W-2:MAN_W] == '0);
    a_mag  = a_zero ? '0 : a0[W-2:0];
    b_mag  = b_zero ? '0 : b0[W-2:0];

    // Order by full magnitude so the subtraction below never goes negative.
    swap   = (b_mag > a_mag);
    mag_l  = swap ? b_mag : a_mag;
    mag_s  = swap ? a_mag : b_mag;
    sign_l = swap ? sb : sa;
    exp_l  = mag_l[W-2:MAN_W];
    exp_s  = mag_s[W-2:MAN_W];
    sig_l  = {exp_l != '0, mag_l[MAN_W-1:0]};
    sig_s  = {exp_s != '0, mag_s[MAN_W-1:0]};
    diff   = exp_l - exp_s;

    // Clamping at AW pushes the whole smaller operand into the sticky half.
    sh = (int'(diff) > AW) ? AW : int'(diff);
    al = {sig_s, 2'b00, {AW{1'b0}}} >> sh;
    ml = {sig_l, 3'b000};
    ms = {al[2*AW-1:AW], |al[AW-1:0]};

    nan1  = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
    spec1 = nan1 || a_inf || b_inf;
    if (nan1)       spec_res1 = QNAN;
    else if (a_inf) spec_res1 = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else            spec_res1 = {sb, EXP_ONES, {MAN_W{1'b0}}};
  end

  logic             v1, s1_spec, s1_sign, s1_sub, s1_zsign;
  logic [W-1:0]     s1_res;
  logic [EXP_W-1:0] s1_exp;
  logic [SW-1:0]    s1_ml, s1_ms;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      s1_spec  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_sub   <= 1'b0;
      s1_zsign <= 1'b0;
      s1_res   <= '0;
      s1_exp   <= '0;
      s1_ml    <= '0;
      s1_ms    <= '0;
    end else if (adv) begin
      v1 <= v0;
      if (v0) begin
        s1_spec  <= spec1;
        s1_sign  <= sign_l;
        s1_sub   <= (sa != sb);
        s1_zsign <= sa && sb;  // zero sum is -0 only when both inputs are -0
        s1_res   <= spec_res1;
        s1_exp   <= exp_l;
        s1_ml    <= ml;
        s1_ms    <= ms;
      end
    end
  end

  // ---------------- S2: add/sub, leading-zero count, normalise ----------------
  logic [SW:0]      sum;
  logic [SW-1:0]    norm;
  logic [EXP_W+1:0] en;
  logic             zero2, flush2, spec2;
  logic [W-1:0]     res2;
  int               lz;

  always_comb begin
    if (s1_sub) sum = {1'b0, s1_ml} - {1'b0, s1_ms};
    else        sum = {1'b0, s1_ml} + {1'b0, s1_ms};

    lz = SW;
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lz = SW - 1 - i;
    end

    if (sum[SW]) begin
      norm = {sum[SW:2], sum[1] | sum[0]};
      en   = {2'b00, s1_exp} + (EXP_W+2)'(1);
    end else begin
      norm = sum[SW-1:0] << lz;
      en   = {2'b00, s1_exp} - (EXP_W+2)'(lz);
    end

    zero2  = (sum == '0);
    flush2 = !zero2 && (en[EXP_W+1] || en == '0);  // biased exponent <= 0
    spec2  = s1_spec || zero2 || flush2;
    res2   = s1_res;
    if (!s1_spec) begin
      if (zero2)       res2 = {s1_zsign, {(W-1){1'b0}}};
      else if (flush2) res2 = {s1_sign, {(W-1){1'b0}}};
    end
  end

  logic             v2, s2_spec, s2_sign;
  logic [W-1:0]     s2_res;
  logic [EXP_W+1:0] s2_exp;
  logic [SW-1:0]    s2_man;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2      <= 1'b0;
      s2_spec <= 1'b0;
      s2_sign <= 1'b0;
      s2_res  <= '0;
      s2_exp  <= '0;
      s2_man  <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) begin
        s2_spec <= spec2;
        s2_sign <= s1_sign;
        s2_res  <= res2;
        s2_exp  <= en;
        s2_man  <= norm;
      end
    end
  end

  // ---------------- S3: round to nearest even, pack ----------------
  logic             rup, ovf3;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W+1:0] er;
  logic [W-1:0]     res3;

  always_comb begin
    rup  = s2_man[2] && (s2_man[1] || s2_man[0] || s2_man[3]);
    rnd  = {1'b0, s2_man[SW-1:3]} + (MAN_W+2)'(rup);
    // A carry out of the mantissa leaves rnd = 10..0, so its low field is already zero.
    er   = s2_exp + (EXP_W+2)'(rnd[MAN_W+1]);
    ovf3 = !s2_spec && (er >= {2'b00, EXP_ONES});
    if (s2_spec)   res3 = s2_res;
    else if (ovf3) res3 = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else           res3 = {s2_sign, er[EXP_W-1:0], rnd[MAN_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) c <= res3;
    end
  end

`ifdef FP_ADDSUB_FLAGS_EN
  // Exception flags travel alongside the data so they line up with c.
  logic       s1_inv, s2_inv, s2_uf;
  logic [3:0] flags3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_inv <= 1'b0;
      s2_inv <= 1'b0;
      s2_uf  <= 1'b0;
      flags  <= '0;
    end else if (adv) begin
      if (v0) s1_inv <= (a_nan && !a0[MAN_W-1]) || (b_nan && !b0[MAN_W-1]) ||
                        (a_inf && b_inf && (sa != sb));
      if (v1) begin
        s2_inv <= s1_inv;
        s2_uf  <= !s1_spec && !zero2 && flush2;
      end
      if (v2) flags <= flags3;
    end
  end

  always_comb begin
    if (s2_spec) flags3 = {s2_inv, 1'b0, s2_uf, s2_uf};
    else         flags3 = {1'b0, ovf3, 1'b0, ovf3 || (|s2_man[2:0])};
  end
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single and half precision instances, hand-computed vectors.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic        h_in_valid, h_in_ready, h_op, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_c;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [3:0]  flags, h_flags;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] c;
    logic [3:0]  f;  // {invalid, overflow, underflow, inexact}
  } vec_t;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c)
`ifdef FP_ADDSUB_FLAGS_EN
    , .flags(flags)
`endif
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op(h_op),
    .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .c(h_c)
`ifdef FP_ADDSUB_FLAGS_EN
    , .flags(h_flags)
`endif
  );

  // Drives one operation with out_ready high and returns the number of edges after the
  // accepting edge until out_valid is seen (10 means it never came). Returns at a negedge
  // while the result is still presented on c/flags.
  task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                       output int lat);
    @(negedge clk);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (c !== 32'h0) begin n_bad++; $display("FAIL reset_c: got %h required 00000000", c); end
    n_cmp++; if (h_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_h_out_valid: got %b required 0", h_out_valid); end
`ifdef FP_ADDSUB_FLAGS_EN
    n_cmp++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %b required 0000", flags); end
`endif
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_arith();
    vec_t t[4];
    int   lat;
    t[0] = '{32'h41800000, 32'h3F800000, 1'b0, 32'h41880000, 4'h0};
    t[1] = '{32'h41800000, 32'h3F800000, 1'b1, 32'h41700000, 4'h0};
    t[2] = '{32'hC1800000, 32'h3F800000, 1'b0, 32'hC1700000, 4'h0};
    t[3] = '{32'hC1800000, 32'h3F800000, 1'b1, 32'hC1880000, 4'h0};
    for (int i = 0; i < 4; i++) begin
      issue(t[i].a, t[i].b, t[i].op, lat);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL arith_latency[%0d]: got %0d required 3", i, lat); end
      n_cmp++; if (c !== t[i].c) begin n_bad++; $display("FAIL arith_c[%0d]: got %h required %h", i, c, t[i].c); end
`ifdef FP_ADDSUB_FLAGS_EN
      n_cmp++; if (flags !== t[i].f) begin n_bad++; $display("FAIL arith_flags[%0d]: got %b required %b", i, flags, t[i].f); end
`endif
    end
  endtask

  task automatic test_rounding();
    vec_t t[5];
    int   lat;
    t[0] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};  // exact cancellation
    t[1] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};  // inf - inf
    t[2] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};  // tie to even, stays
    t[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};  // overflow to inf
    t[4] = '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'h1};  // round carry bumps exponent
    for (int i = 0; i < 5; i++) begin
      issue(t[i].a, t[i].b, t[i].op, lat);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL round_latency[%0d]: got %0d required 3", i, lat); end
      n_cmp++; if (c !== t[i].c) begin n_bad++; $display("FAIL round_c[%0d]: got %h required %h", i, c, t[i].c); end
`ifdef FP_ADDSUB_FLAGS_EN
      n_cmp++; if (flags !== t[i].f) begin n_bad++; $display("FAIL round_flags[%0d]: got %b required %b", i, flags, t[i].f); end
`endif
    end
  endtask

  task automatic test_special();
    vec_t t[9];
    int   lat;
    t[0] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};  // -0 + -0
    t[1] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'h0};  // +0 + -0
    t[2] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0};  // subnormal input as zero
    t[3] = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8};  // signalling NaN
    t[4] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0};  // quiet NaN
    t[5] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'h0};  // inf + finite
    t[6] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};  // finite - inf
    t[7] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'h3};  // subnormal result flushed
    t[8] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'h1};  // huge shift -> sticky only
    for (int i = 0; i < 9; i++) begin
      issue(t[i].a, t[i].b, t[i].op, lat);
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL special_latency[%0d]: got %0d required 3", i, lat); end
      n_cmp++; if (c !== t[i].c) begin n_bad++; $display("FAIL special_c[%0d]: got %h required %h", i, c, t[i].c); end
`ifdef FP_ADDSUB_FLAGS_EN
      n_cmp++; if (flags !== t[i].f) begin n_bad++; $display("FAIL special_flags[%0d]: got %b required %b", i, flags, t[i].f); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[8], vb[8], vc[8];
    logic        vo[8];
    logic [31:0] held = '0;
    logic        stalled = 1'b0;
    int          tx = 0, rx = 0, k = 0, extra = 0;
    va = '{32'h41800000, 32'h41800000, 32'h3F800000, 32'h40000000,
           32'h40400000, 32'hC0000000, 32'h3F800000, 32'h40800000};
    vb = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
           32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40800000};
    vo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vc = '{32'h41880000, 32'h41700000, 32'h40000000, 32'h40400000,
           32'h3F800000, 32'hBF800000, 32'h00000000, 32'h41000000};
    while (rx < 8 && k < 80) begin
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (out_valid !== 1'b1 || c !== held) begin
          n_bad++;
          $display("FAIL b2b_hold: out_valid=%b c=%h required out_valid=1 c=%h", out_valid, c, held);
        end
      end
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      in_valid  = (tx < 8);
      if (tx < 8) begin a = va[tx]; b = vb[tx]; op = vo[tx]; end
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (c !== vc[rx]) begin n_bad++; $display("FAIL b2b_result[%0d]: got %h required %h", rx, c, vc[rx]); end
        rx++;
      end
      stalled = out_valid && !out_ready;
      held    = c;
      if (in_valid && in_ready) tx++;
      k++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (rx !== 8) begin n_bad++; $display("FAIL b2b_count: got %0d results required 8", rx); end
    for (int i = 0; i < 8; i++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL b2b_extra: got %0d extra results required 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, seen = 0;
    out_ready = 1'b1;
    @(negedge clk);
    a = 32'h41800000; b = 32'h3F800000; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h40000000; b = 32'h3F800000; op = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: out_valid=%b required 1", out_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
    n_cmp++; if (c !== 32'h0) begin n_bad++; $display("FAIL rstmid_c: got %h required 00000000", c); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_ghost: got %0d results required 0", seen); end
    issue(32'h40400000, 32'h40000000, 1'b1, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rstmid_latency: got %0d required 3", lat); end
    n_cmp++; if (c !== 32'h3F800000) begin n_bad++; $display("FAIL rstmid_c_after: got %h required 3f800000", c); end
  endtask

  task automatic test_half();
    int lat = 0;
    @(negedge clk);
    h_a = 16'h4C00; h_b = 16'h3C00; h_op = 1'b0; h_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h_in_valid = 1'b0;
    while (!h_out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL half_latency: got %0d required 3", lat); end
    n_cmp++; if (h_c !== 16'h4C40) begin n_bad++; $display("FAIL half_c: got %h required 4c40", h_c); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_rounding();
    test_special();
    test_back_to_back();
    test_reset_mid();
    test_half();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
